// File: rtl/red_pitaya_guitar_pkg.sv
// Shared definitions for the guitar effects register bank: register offsets,
// effect-select encoding, commit FSM states, parameter record and reset values.
package red_pitaya_guitar_pkg;

    // Byte offsets of the register map
    localparam logic [31:0] REG_FX_EN     = 32'h0000_0000;
    localparam logic [31:0] REG_FX_SEL    = 32'h0000_0008;
    localparam logic [31:0] REG_STATUS    = 32'h0000_0010;
    localparam logic [31:0] REG_ID        = 32'h0000_0018;
    localparam logic [31:0] REG_SMP_CNT   = 32'h0000_001C;
    localparam logic [31:0] REG_CLIP_CNT  = 32'h0000_0020;
    localparam logic [31:0] REG_DIST_GAIN = 32'h0000_0088;
    localparam logic [31:0] REG_DIST_CLIP = 32'h0000_0090;
    localparam logic [31:0] REG_DLY_LEN   = 32'h0000_0100;
    localparam logic [31:0] REG_DLY_FB    = 32'h0000_0108;
    localparam logic [31:0] REG_OCT_MIX   = 32'h0000_0180;

    typedef enum logic [1:0] {
        FX_BYPASS  = 2'd0,
        FX_DIST    = 2'd1,
        FX_DELAY   = 2'd2,
        FX_OCTAVER = 2'd3
    } fx_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } commit_state_e;

    // One complete set of effect parameters (used for shadow and active copies)
    typedef struct packed {
        logic        fx_en;
        fx_sel_e     fx_sel;
        logic [7:0]  dist_gain;
        logic [13:0] dist_clip;
        logic [15:0] dly_len;
        logic [7:0]  dly_fb;
        logic [7:0]  oct_mix;
    } guitar_cfg_t;

    localparam logic [13:0] DIST_CLIP_RST = 14'h1FFF;

    localparam guitar_cfg_t CFG_RST = '{
        fx_en:     1'b0,
        fx_sel:    FX_BYPASS,
        dist_gain: 8'd0,
        dist_clip: DIST_CLIP_RST,
        dly_len:   16'd0,
        dly_fb:    8'd0,
        oct_mix:   8'd0
    };

    // Replace the bytes of old_v selected by sel with the matching bytes of new_v
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/red_pitaya_guitar_regs_commit.sv
// Shadow-to-active parameter commit. A bus write arms the FSM (PEND); the next
// sample strobe copies the whole shadow set into the active set at once and
// pulses cfg_upd_o, so the datapath never sees a half-updated configuration.
module red_pitaya_guitar_regs_commit
    import red_pitaya_guitar_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  guitar_cfg_t shadow_i,
    input  logic        rw_wr_i,
    input  logic        sample_stb_i,
    output guitar_cfg_t active_o,
    output logic        pending_o,
    output logic        cfg_upd_o
);

    commit_state_e state_q, state_d;
    guitar_cfg_t   active_q, active_d;
    logic          upd_q, upd_d;

    // Next state: commit on strobe while pending; a write (even a coincident
    // one) leaves the FSM pending, its value goes out on the following strobe
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        upd_d    = 1'b0;
        if (state_q == ST_PEND && sample_stb_i) begin
            active_d = shadow_i;
            upd_d    = 1'b1;
            state_d  = ST_IDLE;
        end
        if (rw_wr_i) state_d = ST_PEND;
    end

    // State, active parameter set and update pulse registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            active_q <= CFG_RST;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            upd_q    <= upd_d;
        end
    end

    assign active_o  = active_q;
    assign pending_o = (state_q == ST_PEND);
    assign cfg_upd_o = upd_q;

endmodule

// File: rtl/red_pitaya_guitar_regs.sv
// Guitar effects register bank on the sys bus: decodes reads/writes, holds
// shadow parameters, exposes ID/status/sample counter.
// Optional clip counter at 0x20 is built when GUITAR_REGS_CLIP_CNT_EN is defined.
module red_pitaya_guitar_regs
    import red_pitaya_guitar_pkg::*;
#(
    parameter int unsigned  ADDR_W  = 20,
    parameter logic [31:0]  ID_VAL  = 32'h4754_0001,
    parameter logic [15:0]  DLY_MAX = 16'd16383
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] sys_addr_i,
    input  logic [31:0] sys_wdata_i,
    input  logic [3:0]  sys_sel_i,
    input  logic        sys_wen_i,
    input  logic        sys_ren_i,
    output logic [31:0] sys_rdata_o,
    output logic        sys_err_o,
    output logic        sys_ack_o,
    input  logic        sample_stb_i,
    input  logic        clip_i,
    output logic        fx_en_o,
    output logic [1:0]  fx_sel_o,
    output logic [7:0]  dist_gain_o,
    output logic [13:0] dist_clip_o,
    output logic [15:0] dly_len_o,
    output logic [7:0]  dly_fb_o,
    output logic [7:0]  oct_mix_o,
    output logic        cfg_upd_o
);

    localparam logic [31:0] ADDR_MASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'h1 << ADDR_W) - 32'h1);

    guitar_cfg_t shadow_q, shadow_d, active;
    logic        pending;
    logic [31:0] addr, old_v, merged, ro_val, rd_val, clip_val;
    logic [15:0] dly_new;
    logic        rd_req, is_rw, is_ro, rw_wr, err_d;
    logic        ack_q, ack_d, err_q;
    logic [31:0] rdata_q, rdata_d, smp_cnt_q, smp_cnt_d;

    // Address decode, byte-merged shadow update and read mux (write wins over read)
    always_comb begin
        addr     = sys_addr_i & ADDR_MASK;
        rd_req   = sys_ren_i & ~sys_wen_i;
        is_rw    = 1'b1;
        is_ro    = 1'b0;
        old_v    = '0;
        ro_val   = '0;
        case (addr)
            REG_FX_EN:     old_v = {31'b0, shadow_q.fx_en};
            REG_FX_SEL:    old_v = {30'b0, shadow_q.fx_sel};
            REG_DIST_GAIN: old_v = {24'b0, shadow_q.dist_gain};
            REG_DIST_CLIP: old_v = {18'b0, shadow_q.dist_clip};
            REG_DLY_LEN:   old_v = {16'b0, shadow_q.dly_len};
            REG_DLY_FB:    old_v = {24'b0, shadow_q.dly_fb};
            REG_OCT_MIX:   old_v = {24'b0, shadow_q.oct_mix};
            REG_STATUS:   begin is_rw = 1'b0; is_ro = 1'b1; ro_val = {30'b0, pending, active.fx_en}; end
            REG_ID:       begin is_rw = 1'b0; is_ro = 1'b1; ro_val = ID_VAL; end
            REG_SMP_CNT:  begin is_rw = 1'b0; is_ro = 1'b1; ro_val = smp_cnt_q; end
            REG_CLIP_CNT: begin is_rw = 1'b0; is_ro = 1'b1; ro_val = clip_val; end
            default:      is_rw = 1'b0;
        endcase
        rd_val  = is_rw ? old_v : ro_val;
        merged  = byte_merge(old_v, sys_wdata_i, sys_sel_i);
        dly_new = 16'(merged);
        rw_wr   = sys_wen_i & is_rw;

        shadow_d = shadow_q;
        if (rw_wr) begin
            case (addr)
                REG_FX_EN:     shadow_d.fx_en     = merged[0];
                REG_FX_SEL:    shadow_d.fx_sel    = fx_sel_e'(merged[1:0]);
                REG_DIST_GAIN: shadow_d.dist_gain = 8'(merged);
                REG_DIST_CLIP: shadow_d.dist_clip = 14'(merged);
                REG_DLY_LEN:   shadow_d.dly_len   = (dly_new > DLY_MAX) ? DLY_MAX : dly_new;
                REG_DLY_FB:    shadow_d.dly_fb    = 8'(merged);
                REG_OCT_MIX:   shadow_d.oct_mix   = 8'(merged);
                default:       shadow_d = shadow_q;
            endcase
        end

        ack_d     = sys_wen_i | sys_ren_i;
        err_d     = (sys_wen_i & ~is_rw) | (rd_req & ~is_rw & ~is_ro);
        rdata_d   = rd_req ? rd_val : 32'h0;
        smp_cnt_d = sample_stb_i ? smp_cnt_q + 32'd1 : smp_cnt_q;
    end

    // Shadow set, bus response and sample counter registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shadow_q  <= CFG_RST;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            smp_cnt_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            smp_cnt_q <= smp_cnt_d;
        end
    end

`ifdef GUITAR_REGS_CLIP_CNT_EN
    logic [15:0] clip_cnt_q, clip_cnt_d;

    // Saturating clip counter; a read clears it, a coincident clip restarts at 1
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (rd_req && addr == REG_CLIP_CNT)
            clip_cnt_d = {15'b0, clip_i};
        else if (clip_i && clip_cnt_q != 16'hFFFF)
            clip_cnt_d = clip_cnt_q + 16'd1;
    end

    // Clip counter register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) clip_cnt_q <= '0;
        else         clip_cnt_q <= clip_cnt_d;
    end

    assign clip_val = {16'b0, clip_cnt_q};
`else
    logic clip_unused;
    assign clip_unused = clip_i;
    assign clip_val    = '0;
`endif

    red_pitaya_guitar_regs_commit u_commit (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .shadow_i     (shadow_q),
        .rw_wr_i      (rw_wr),
        .sample_stb_i (sample_stb_i),
        .active_o     (active),
        .pending_o    (pending),
        .cfg_upd_o    (cfg_upd_o)
    );

    assign sys_ack_o   = ack_q;
    assign sys_err_o   = err_q;
    assign sys_rdata_o = rdata_q;
    assign fx_en_o     = active.fx_en;
    assign fx_sel_o    = active.fx_sel;
    assign dist_gain_o = active.dist_gain;
    assign dist_clip_o = active.dist_clip;
    assign dly_len_o   = active.dly_len;
    assign dly_fb_o    = active.dly_fb;
    assign oct_mix_o   = active.oct_mix;

endmodule

// File: tb/tb_red_pitaya_guitar_regs.sv
// Directed bench for the guitar register bank: a vector table of bus
// transactions plus hand-written sequences for commit timing, collisions,
// back-to-back requests, reset mid-transaction and the clip counter.
module tb_red_pitaya_guitar_regs;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] sys_addr = '0, sys_wdata = '0;
    logic [3:0]  sys_sel = '0;
    logic        sys_wen = 1'b0, sys_ren = 1'b0;
    logic [31:0] sys_rdata;
    logic        sys_err, sys_ack;
    logic        sample_stb = 1'b0, clip = 1'b0;
    logic        fx_en;
    logic [1:0]  fx_sel;
    logic [7:0]  dist_gain, dly_fb, oct_mix;
    logic [13:0] dist_clip;
    logic [15:0] dly_len;
    logic        cfg_upd;

    int n_chk = 0;
    int n_err = 0;

    red_pitaya_guitar_regs dut (
        .clk_i(clk), .rstn_i(rstn),
        .sys_addr_i(sys_addr), .sys_wdata_i(sys_wdata), .sys_sel_i(sys_sel),
        .sys_wen_i(sys_wen), .sys_ren_i(sys_ren),
        .sys_rdata_o(sys_rdata), .sys_err_o(sys_err), .sys_ack_o(sys_ack),
        .sample_stb_i(sample_stb), .clip_i(clip),
        .fx_en_o(fx_en), .fx_sel_o(fx_sel), .dist_gain_o(dist_gain),
        .dist_clip_o(dist_clip), .dly_len_o(dly_len), .dly_fb_o(dly_fb),
        .oct_mix_o(oct_mix), .cfg_upd_o(cfg_upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] er_d, input logic er);
        vec_t v;
        v.we = we; v.re = re; v.addr = a; v.wdata = d; v.sel = s;
        v.exp_rdata = er_d; v.exp_err = er;
        vecs.push_back(v);
    endtask

    // One-cycle request; called at posedge+1, returns at next posedge+1
    task automatic xfer(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic ak, output logic er, output logic [31:0] rd);
        sys_wen = we; sys_ren = re; sys_addr = a; sys_wdata = d; sys_sel = s;
        @(posedge clk); #1;
        sys_wen = 1'b0; sys_ren = 1'b0;
        ak = sys_ack; er = sys_err; rd = sys_rdata;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a,
                          input logic [31:0] exp, input logic exp_err);
        logic ak, er;
        logic [31:0] rd;
        xfer(1'b0, 1'b1, a, 32'h0, 4'h0, ak, er, rd);
        chk({name, " ack"}, {31'b0, ak}, 32'd1);
        chk({name, " err"}, {31'b0, er}, {31'b0, exp_err});
        chk({name, " rdata"}, rd, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic ak, er;
        logic [31:0] rd;
        xfer(1'b1, 1'b0, a, d, 4'hF, ak, er, rd);
        chk("wr ack", {31'b0, ak}, 32'd1);
    endtask

    task automatic strobe();
        sample_stb = 1'b1;
        @(posedge clk); #1;
        sample_stb = 1'b0;
    endtask

    initial begin
        logic ak, er;
        logic [31:0] rd;

        // Vector table: {we, re, addr, wdata, sel, expected rdata, expected err}
        add(0, 1, 32'h18,  32'h0,         4'h0, 32'h4754_0001, 0);
        add(0, 1, 32'h90,  32'h0,         4'h0, 32'h0000_1FFF, 0);
        add(0, 1, 32'h10,  32'h0,         4'h0, 32'h0,         0);
        add(0, 1, 32'h1C,  32'h0,         4'h0, 32'h0,         0);
        add(1, 0, 32'h88,  32'h5,         4'hF, 32'h0,         0);
        add(1, 0, 32'h90,  32'h2,         4'hF, 32'h0,         0);
        add(0, 1, 32'h88,  32'h0,         4'h0, 32'h5,         0);
        add(0, 1, 32'h90,  32'h0,         4'h0, 32'h2,         0);
        add(0, 1, 32'h10,  32'h0,         4'h0, 32'h2,         0);
        add(1, 0, 32'h100, 32'h0001_FFFF, 4'h3, 32'h0,         0);
        add(0, 1, 32'h100, 32'h0,         4'h0, 32'h3FFF,      0);
        add(1, 0, 32'h100, 32'h3FFF,      4'hF, 32'h0,         0);
        add(0, 1, 32'h100, 32'h0,         4'h0, 32'h3FFF,      0);
        add(1, 0, 32'h100, 32'h4000,      4'hF, 32'h0,         0);
        add(0, 1, 32'h100, 32'h0,         4'h0, 32'h3FFF,      0);
        add(1, 0, 32'h100, 32'hFFFF_1234, 4'h3, 32'h0,         0);
        add(0, 1, 32'h100, 32'h0,         4'h0, 32'h1234,      0);
        add(1, 0, 32'h108, 32'hAABB_CC12, 4'h1, 32'h0,         0);
        add(1, 0, 32'h108, 32'h0000_3400, 4'h2, 32'h0,         0);
        add(0, 1, 32'h108, 32'h0,         4'h0, 32'h12,        0);
        add(1, 0, 32'h180, 32'hFFFF_FF7E, 4'hF, 32'h0,         0);
        add(0, 1, 32'h180, 32'h0,         4'h0, 32'h7E,        0);
        add(0, 1, 32'h1F0, 32'h0,         4'h0, 32'h0,         1);
        add(1, 0, 32'h1F0, 32'h1,         4'hF, 32'h0,         1);
        add(1, 0, 32'h18,  32'h0,         4'hF, 32'h0,         1);
        add(0, 1, 32'h18,  32'h0,         4'h0, 32'h4754_0001, 0);
        add(0, 1, 32'h7FF0_0018, 32'h0,   4'h0, 32'h4754_0001, 0);
        add(1, 0, 32'h0,   32'hFFFF_FFFF, 4'hF, 32'h0,         0);
        add(0, 1, 32'h0,   32'h0,         4'h0, 32'h1,         0);
        add(0, 1, 32'h20,  32'h0,         4'h0, 32'h0,         0);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        chk("rst ack", {31'b0, sys_ack}, 32'd0);
        chk("rst err", {31'b0, sys_err}, 32'd0);
        chk("rst rdata", sys_rdata, 32'd0);
        chk("rst outs", {fx_en, fx_sel, dist_gain, dly_len, dly_fb, oct_mix, cfg_upd},
            32'd0);
        @(posedge clk); #1;

        // Table-driven transactions, issued back-to-back
        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].sel, ak, er, rd);
            chk($sformatf("vec%0d ack", i), {31'b0, ak}, 32'd1);
            chk($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
        end
        @(posedge clk); #1;
        chk("ack idle", {31'b0, sys_ack}, 32'd0);

        // Nothing committed yet; first strobe applies everything at once
        chk("pre-commit gain", {24'b0, dist_gain}, 32'd0);
        chk("pre-commit fx_en", {31'b0, fx_en}, 32'd0);
        strobe();
        chk("commit gain", {24'b0, dist_gain}, 32'd5);
        chk("commit clip", {18'b0, dist_clip}, 32'd2);
        chk("commit dly_len", {16'b0, dly_len}, 32'h1234);
        chk("commit dly_fb", {24'b0, dly_fb}, 32'h12);
        chk("commit oct_mix", {24'b0, oct_mix}, 32'h7E);
        chk("commit fx_en", {31'b0, fx_en}, 32'd1);
        chk("commit upd", {31'b0, cfg_upd}, 32'd1);
        @(posedge clk); #1;
        chk("upd single", {31'b0, cfg_upd}, 32'd0);
        rd_chk("status idle", 32'h10, 32'h1, 1'b0);

        // wen and ren together: write wins, one ack
        xfer(1'b1, 1'b1, 32'h08, 32'h2, 4'hF, ak, er, rd);
        chk("wr+rd ack", {31'b0, ak}, 32'd1);
        chk("wr+rd err", {31'b0, er}, 32'd0);
        chk("wr+rd rdata", rd, 32'd0);
        @(posedge clk); #1;
        chk("wr+rd one ack", {31'b0, sys_ack}, 32'd0);
        rd_chk("fx_sel shadow", 32'h08, 32'h2, 1'b0);
        chk("fx_sel not active", {30'b0, fx_sel}, 32'd0);

        // Write coincident with strobe: old shadow commits, new one waits
        sample_stb = 1'b1;
        wr(32'h08, 32'h3);
        sample_stb = 1'b0;
        chk("coinc fx_sel", {30'b0, fx_sel}, 32'd2);
        chk("coinc upd", {31'b0, cfg_upd}, 32'd1);
        rd_chk("coinc status", 32'h10, 32'h3, 1'b0);
        strobe();
        chk("follow fx_sel", {30'b0, fx_sel}, 32'd3);
        chk("follow upd", {31'b0, cfg_upd}, 32'd1);
        rd_chk("follow status", 32'h10, 32'h1, 1'b0);

        // Strobe with nothing pending: no commit pulse
        strobe();
        chk("idle stb upd", {31'b0, cfg_upd}, 32'd0);
        rd_chk("smp cnt", 32'h1C, 32'd4, 1'b0);

        // Back-to-back reads
        xfer(1'b0, 1'b1, 32'h18, 32'h0, 4'h0, ak, er, rd);
        chk("b2b0 rdata", rd, 32'h4754_0001);
        xfer(1'b0, 1'b1, 32'h88, 32'h0, 4'h0, ak, er, rd);
        chk("b2b1 ack", {31'b0, ak}, 32'd1);
        chk("b2b1 rdata", rd, 32'd5);

        // Reset during a request with a commit armed: nothing survives
        wr(32'h88, 32'h77);
        sys_ren = 1'b1; sys_addr = 32'h18; sample_stb = 1'b1;
        #2 rstn = 1'b0;
        @(posedge clk); #1;
        chk("rst mid ack", {31'b0, sys_ack}, 32'd0);
        chk("rst mid upd", {31'b0, cfg_upd}, 32'd0);
        chk("rst mid gain", {24'b0, dist_gain}, 32'd0);
        sys_ren = 1'b0; sample_stb = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;
        rd_chk("rst mid shadow", 32'h88, 32'd0, 1'b0);
        rd_chk("rst mid status", 32'h10, 32'd0, 1'b0);
        rd_chk("rst mid smp", 32'h1C, 32'd0, 1'b0);

`ifdef GUITAR_REGS_CLIP_CNT_EN
        // Saturation, clear-on-read, clip coincident with the clearing read
        clip = 1'b1;
        repeat (70000) @(posedge clk);
        #1 clip = 1'b0;
        rd_chk("clip sat", 32'h20, 32'hFFFF, 1'b0);
        rd_chk("clip clr", 32'h20, 32'h0, 1'b0);
        clip = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        xfer(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, ak, er, rd);
        clip = 1'b0;
        chk("clip coinc rdata", rd, 32'd3);
        rd_chk("clip coinc left", 32'h20, 32'd1, 1'b0);
`else
        clip = 1'b1;
        repeat (5) @(posedge clk);
        #1 clip = 1'b0;
        rd_chk("clip absent", 32'h20, 32'h0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
